level_tracker: RTL and testbench

//  Parametrised successor of the floor tracker: consumes the decoded inbound byte stream,

---
 rtl/level_tracker.sv | 185 ++++++++++++++++++
 tb/tb_level_tracker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/level_tracker.sv
// Tracks a signed level driven by up/down step bytes and emits a per-record result burst.
// Optional LEVEL_TRACKER_STATS_EN adds a third burst word carrying the record's maximum level.
module level_tracker #(
  parameter int unsigned RESULT_WIDTH = 16,
  parameter logic [7:0]  UP_CHAR      = 8'h28,
  parameter logic [7:0]  DOWN_CHAR    = 8'h29,
  parameter logic [7:0]  TERM_CHAR    = 8'h0A,
  parameter int          TARGET_LEVEL = -1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    inbound_valid,
  input  logic [7:0]              inbound_data,
  output logic                    outbound_valid,
  output logic [RESULT_WIDTH-1:0] outbound_data,
  output logic                    outbound_last,
  output logic                    overflow,
  output logic                    busy
);

  localparam logic [RESULT_WIDTH-1:0] TargetLvl = RESULT_WIDTH'(TARGET_LEVEL);
  localparam logic [RESULT_WIDTH-1:0] PosMax    = {RESULT_WIDTH{1'b1}};
  localparam logic [RESULT_WIDTH-1:0] LevelMax  = {1'b0, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic [RESULT_WIDTH-1:0] LevelMin  = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

`ifdef LEVEL_TRACKER_STATS_EN
  typedef enum logic [1:0] {StTrack, StEmitLevel, StEmitPos, StEmitMax} state_e;
`else
  typedef enum logic [1:0] {StTrack, StEmitLevel, StEmitPos} state_e;
`endif

  state_e                  state_q, state_d;
  logic [RESULT_WIDTH-1:0] level_q, level_d;
  logic [RESULT_WIDTH-1:0] pos_q, pos_d;
  logic [RESULT_WIDTH-1:0] hit_pos_q, hit_pos_d;
  logic                    hit_seen_q, hit_seen_d;
  logic                    ovf_q, ovf_d;
  logic                    first_byte_q, first_byte_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [RESULT_WIDTH-1:0] out_data_q, out_data_d;
`ifdef LEVEL_TRACKER_STATS_EN
  logic [RESULT_WIDTH-1:0] max_q, max_d;
`endif

  logic                    step_up, step_dn, clear_rec;
  logic [RESULT_WIDTH-1:0] level_step, pos_step;

  assign step_up    = inbound_valid && (inbound_data == UP_CHAR);
  assign step_dn    = inbound_valid && (inbound_data == DOWN_CHAR);
  assign level_step = step_up ? level_q + 1'b1 : level_q - 1'b1;
  assign pos_step   = (pos_q == PosMax) ? pos_q : pos_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    pos_d        = pos_q;
    hit_pos_d    = hit_pos_q;
    hit_seen_d   = hit_seen_q;
    ovf_d        = ovf_q;
    first_byte_d = first_byte_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    out_data_d   = out_data_q;
    clear_rec    = 1'b0;
`ifdef LEVEL_TRACKER_STATS_EN
    max_d        = max_q;
`endif

    case (state_q)
      StTrack: begin
        if (inbound_valid) begin
          // Overflow from the previous record survives until the next record really starts.
          if (first_byte_q) begin
            ovf_d        = 1'b0;
            first_byte_d = 1'b0;
          end
          if (step_up || step_dn) begin
            level_d = level_step;
            pos_d   = pos_step;
            if ((step_up && level_q == LevelMax) || (step_dn && level_q == LevelMin)) begin
              ovf_d = 1'b1;
            end
            if (!hit_seen_q && level_step == TargetLvl) begin
              hit_pos_d  = pos_step;
              hit_seen_d = 1'b1;
            end
`ifdef LEVEL_TRACKER_STATS_EN
            if ($signed(level_step) > $signed(max_q)) max_d = level_step;
`endif
          end else if (inbound_data == TERM_CHAR) begin
            state_d = StEmitLevel;
          end
        end
      end
      StEmitLevel: state_d = StEmitPos;
`ifdef LEVEL_TRACKER_STATS_EN
      StEmitPos: state_d = StEmitMax;
      StEmitMax: begin
        state_d   = StTrack;
        clear_rec = 1'b1;
      end
`else
      StEmitPos: begin
        state_d   = StTrack;
        clear_rec = 1'b1;
      end
`endif
      default: state_d = StTrack;
    endcase

    if (clear_rec) begin
      level_d      = '0;
      pos_d        = '0;
      hit_pos_d    = '0;
      hit_seen_d   = 1'b0;
      first_byte_d = 1'b1;
`ifdef LEVEL_TRACKER_STATS_EN
      max_d        = '0;
`endif
    end

    // Output flops are loaded from the state being entered so they line up with that state.
    case (state_d)
      StEmitLevel: begin
        out_valid_d = 1'b1;
        out_data_d  = level_q;
      end
      StEmitPos: begin
        out_valid_d = 1'b1;
        out_data_d  = hit_pos_q;
`ifndef LEVEL_TRACKER_STATS_EN
        out_last_d  = 1'b1;
`endif
      end
`ifdef LEVEL_TRACKER_STATS_EN
      StEmitMax: begin
        out_valid_d = 1'b1;
        out_data_d  = max_q;
        out_last_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StTrack;
      level_q      <= '0;
      pos_q        <= '0;
      hit_pos_q    <= '0;
      hit_seen_q   <= 1'b0;
      ovf_q        <= 1'b0;
      first_byte_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
`ifdef LEVEL_TRACKER_STATS_EN
      max_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      pos_q        <= pos_d;
      hit_pos_q    <= hit_pos_d;
      hit_seen_q   <= hit_seen_d;
      ovf_q        <= ovf_d;
      first_byte_q <= first_byte_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
`ifdef LEVEL_TRACKER_STATS_EN
      max_q        <= max_d;
`endif
    end
  end

  assign outbound_valid = out_valid_q;
  assign outbound_data  = out_data_q;
  assign outbound_last  = out_last_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != StTrack);

endmodule

// File: tb/tb_level_tracker.sv
// Directed bench for level_tracker: a 16-bit default instance and a 4-bit instance
// (TARGET_LEVEL 0) for wrap and zero-target cases.
module tb_level_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_valid4;
  logic [7:0]  in_data;
  logic        ov16, ol16, of16, bz16;
  logic [15:0] od16;
  logic        ov4, ol4, of4, bz4;
  logic [3:0]  od4;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  level_tracker dut (
    .clk(clk), .reset_n(reset_n), .inbound_valid(in_valid), .inbound_data(in_data),
    .outbound_valid(ov16), .outbound_data(od16), .outbound_last(ol16),
    .overflow(of16), .busy(bz16)
  );

  level_tracker #(.RESULT_WIDTH(4), .TARGET_LEVEL(0)) dut4 (
    .clk(clk), .reset_n(reset_n), .inbound_valid(in_valid4), .inbound_data(in_data),
    .outbound_valid(ov4), .outbound_data(od4), .outbound_last(ol4),
    .overflow(of4), .busy(bz4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic v, output logic l, output logic b,
                        output logic [15:0] d);
    v = sel ? ov4 : ov16;
    l = sel ? ol4 : ol16;
    b = sel ? bz4 : bz16;
    d = sel ? {12'h000, od4} : od16;
  endtask

  task automatic put(input bit sel, input logic [7:0] b);
    @(negedge clk);
    in_data = b;
    if (sel) in_valid4 = 1'b1;
    else     in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
  endtask

  task automatic put_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) put(sel, s[i]);
  endtask

  // Call right after the terminator was accepted; optionally offers ')' during EMIT_LEVEL.
  task automatic expect_burst(input bit sel, input string tag, input logic [15:0] lvl,
                              input logic [15:0] pos, input logic [15:0] mx, input bit inject);
    logic v, l, b;
    logic [15:0] d, last_word;
    sample(sel, v, l, b, d);
    check({tag, ".w0.valid"}, v, 1);
    check({tag, ".w0.data"}, d, lvl);
    check({tag, ".w0.last"}, l, 0);
    check({tag, ".w0.busy"}, b, 1);
    if (inject) begin
      in_data = 8'h29;
      if (sel) in_valid4 = 1'b1;
      else     in_valid  = 1'b1;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    sample(sel, v, l, b, d);
    check({tag, ".w1.valid"}, v, 1);
    check({tag, ".w1.data"}, d, pos);
`ifdef LEVEL_TRACKER_STATS_EN
    check({tag, ".w1.last"}, l, 0);
    @(negedge clk);
    sample(sel, v, l, b, d);
    check({tag, ".w2.valid"}, v, 1);
    check({tag, ".w2.data"}, d, mx);
    check({tag, ".w2.last"}, l, 1);
    last_word = mx;
`else
    check({tag, ".w1.last"}, l, 1);
    last_word = pos;
`endif
    @(negedge clk);
    sample(sel, v, l, b, d);
    check({tag, ".end.valid"}, v, 0);
    check({tag, ".end.last"}, l, 0);
    check({tag, ".end.busy"}, b, 0);
    check({tag, ".end.hold"}, d, last_word);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    in_data   = 8'h00;
    #12;
    check("rst.valid", ov16, 0);
    check("rst.data", od16, 0);
    check("rst.last", ol16, 0);
    check("rst.ovf", of16, 0);
    check("rst.busy", bz16, 0);
    check("rst4.data", od4, 0);
    @(negedge clk);
    reset_n = 1'b1;

    put_str(0, "(()"); put(0, 8'h0A);
    expect_burst(0, "t1", 16'd1, 16'd0, 16'd2, 0);
    check("t1.ovf", of16, 0);

    put_str(0, "())"); put(0, 8'h0A);
    expect_burst(0, "t2a", 16'hFFFF, 16'd3, 16'd1, 0);
    put_str(0, "()())"); put(0, 8'h0A);
    expect_burst(0, "t2b", 16'hFFFF, 16'd5, 16'd1, 0);

    put(0, 8'h0A);
    expect_burst(0, "t3empty", 16'd0, 16'd0, 16'd0, 0);
    put_str(0, "a(b)"); put(0, 8'h0A);
    expect_burst(0, "t3junk", 16'd0, 16'd0, 16'd1, 0);

    // A dropped ')' would have hit level -1 at position 1.
    put(0, 8'h0A);
    expect_burst(0, "busydrop", 16'd0, 16'd0, 16'd0, 1);

    put_str(0, "(("); put(0, 8'h0A);
    check("t5.pre.valid", ov16, 1);
    #1 reset_n = 1'b0;
    #1;
    check("t5.rst.valid", ov16, 0);
    check("t5.rst.busy", bz16, 0);
    check("t5.rst.data", od16, 0);
    @(negedge clk);
    reset_n = 1'b1;
    put(0, 8'h28); put(0, 8'h0A);
    expect_burst(0, "t5post", 16'd1, 16'd0, 16'd1, 0);

    put_str(1, "(((((((("); put(1, 8'h0A);
    expect_burst(1, "t4wrap", 16'h0008, 16'd0, 16'd7, 0);
    check("t4.ovf.after", of4, 1);
    put(1, 8'h28);
    check("t4.ovf.clear", of4, 0);
    put(1, 8'h29); put(1, 8'h0A);
    expect_burst(1, "t4tgt0", 16'd0, 16'd2, 16'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
